// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: sequences MOVE/INC/LOAD/READ transfers over a shared register bus.
// Ports: clk, RST (sync, active-low), REQ/OP/SRC/DST/DIN request, BIN bus sample,
//   BOUT tri-state bus drive, LDBUS/WR/INC one-hot strobes, BUSY/DONE/ERR status, RDATA.
module bus_xfer_ctrl #(
  parameter int NREG = 8,
  parameter int SELW = 3,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            REQ,
  input  logic [1:0]      OP,
  input  logic [SELW-1:0] SRC,
  input  logic [SELW-1:0] DST,
  input  logic [DW-1:0]   DIN,
  input  logic [DW-1:0]   BIN,
  output logic [DW-1:0]   BOUT,
  output logic [NREG-1:0] LDBUS,
  output logic [NREG-1:0] WR,
  output logic [NREG-1:0] INC,
  output logic            BUSY,
  output logic            DONE,
  output logic            ERR,
  output logic [DW-1:0]   RDATA
);

  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    WRITE,
    INCR
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [1:0]      op_q;
  logic [SELW-1:0] src_q;
  logic [SELW-1:0] dst_q;
  logic [DW-1:0]   din_q;

  logic [NREG-1:0] ld_q;
  logic [NREG-1:0] wr_q;
  logic [NREG-1:0] inc_q;
  logic [DW-1:0]   bout_q;
  logic            oe_q;
  logic            done_q;
  logic            err_q;
  logic [DW-1:0]   rdata_q;

  logic [NREG-1:0] ld_nxt;
  logic [NREG-1:0] wr_nxt;
  logic [NREG-1:0] inc_nxt;
  logic [DW-1:0]   bout_nxt;
  logic            oe_nxt;
  logic            done_nxt;
  logic            err_nxt;
  logic            accept;
  logic            legal;

  function automatic logic [NREG-1:0] dec(
    input logic [SELW-1:0] idx
  );
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) begin
      v[i] = (int'(idx) == i);
    end
    return v;
  endfunction

  function automatic logic in_rng(
    input logic [SELW-1:0] idx
  );
    return int'(idx) < NREG;
  endfunction

  // Only the indices an opcode actually uses are range-checked.
  always_comb begin
    legal = 1'b0;
    unique case (OP)
      OP_MOVE: legal = in_rng(SRC) && in_rng(DST)
                       && (SRC != DST);
      OP_INC,
      OP_LOAD: legal = in_rng(DST);
      default: legal = in_rng(SRC);
    endcase
  end

  // Strobes are computed one cycle ahead and registered,
  // so every bus control output comes straight from a flop.
  always_comb begin
    state_nxt = state;
    ld_nxt    = '0;
    wr_nxt    = '0;
    inc_nxt   = '0;
    bout_nxt  = '0;
    oe_nxt    = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (REQ) begin
          if (!legal) begin
            done_nxt = 1'b1;
            err_nxt  = 1'b1;
          end else begin
            accept = 1'b1;
            if (OP == OP_INC) begin
              state_nxt = INCR;
              inc_nxt   = dec(DST);
            end else begin
              state_nxt = DRIVE;
              if (OP == OP_LOAD) begin
                oe_nxt   = 1'b1;
                bout_nxt = DIN;
              end else begin
                ld_nxt = dec(SRC);
              end
            end
          end
        end
      end
      DRIVE: begin
        state_nxt = WRITE;
        if (op_q == OP_LOAD) begin
          oe_nxt   = 1'b1;
          bout_nxt = din_q;
        end else begin
          ld_nxt = dec(src_q);
        end
        if (op_q != OP_READ) begin
          wr_nxt = dec(dst_q);
        end
      end
      WRITE,
      INCR: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state   <= IDLE;
      op_q    <= OP_MOVE;
      src_q   <= '0;
      dst_q   <= '0;
      din_q   <= '0;
      ld_q    <= '0;
      wr_q    <= '0;
      inc_q   <= '0;
      bout_q  <= '0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state  <= state_nxt;
      ld_q   <= ld_nxt;
      wr_q   <= wr_nxt;
      inc_q  <= inc_nxt;
      bout_q <= bout_nxt;
      oe_q   <= oe_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
      if (accept) begin
        op_q  <= OP;
        src_q <= SRC;
        dst_q <= DST;
        din_q <= DIN;
      end
      // Capture on the WRITE edge: source has driven the bus two cycles.
      if (state == WRITE && op_q == OP_READ) begin
        rdata_q <= BIN;
      end
    end
  end

  assign BOUT  = oe_q ? bout_q : {DW{1'bz}};
  assign LDBUS = ld_q;
  assign WR    = wr_q;
  assign INC   = inc_q;
  assign BUSY  = (state != IDLE);
  assign DONE  = done_q;
  assign ERR   = err_q;
  assign RDATA = rdata_q;

endmodule

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 Parameter NREG, default 8: number of bus registers controlled.
REQ-002 Parameter SELW, default 3: register select width; NREG SHALL be <= 2**SELW.
REQ-003 Parameter DW, default 16: bus data width.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 RST  in  1  synchronous, active-low reset; sampled on posedge clk.
REQ-006 REQ  in  1  transfer request; sampled only in IDLE.
REQ-007 OP  in  2  00 MOVE, 01 INC, 10 LOAD (DIN to register), 11 READ (register to RDATA).
REQ-008 SRC  in  SELW  source register index (MOVE, READ).
REQ-009 DST  in  SELW  destination register index (MOVE, INC, LOAD).
REQ-010 DIN  in  DW  external data for LOAD.
REQ-011 BIN  in  DW  shared bus sample.
REQ-012 BOUT  out  DW  controller bus drive; high-Z when not driving.
REQ-013 LDBUS  out  NREG  one-hot register bus-drive enables.
REQ-014 WR  out  NREG  one-hot register write strobes.
REQ-015 INC  out  NREG  one-hot register increment strobes.
REQ-016 BUSY  out  1  high while a transfer is in progress.
REQ-017 DONE  out  1  one-cycle completion pulse.
REQ-018 ERR  out  1  one-cycle rejection pulse, coincident with DONE.
REQ-019 RDATA  out  DW  last value captured by READ.

Function
REQ-020 FSM states SHALL be IDLE, DRIVE, WRITE, INCR; LDBUS/WR/INC/BOUT SHALL be registered, glitch-free.
REQ-021 In IDLE with REQ=1 at posedge T, OP/SRC/DST/DIN SHALL be latched; BUSY=1 from T+1 until return to IDLE.
REQ-022 MOVE: DRIVE at T+1 (LDBUS[SRC]=1); WRITE at T+2 (LDBUS[SRC]=1, WR[DST]=1); IDLE at T+3 with DONE=1, BUSY=0.
REQ-023 LOAD: DRIVE at T+1 (BOUT=latched DIN); WRITE at T+2 (BOUT=DIN, WR[DST]=1); DONE at T+3; SRC ignored.
REQ-024 READ: DRIVE at T+1 (LDBUS[SRC]=1); WRITE at T+2 (LDBUS[SRC]=1, no WR); RDATA<=BIN at end of T+2; DONE at T+3; DST ignored.
REQ-025 INC: INCR at T+1 (INC[DST]=1 for exactly one cycle); DONE at T+2.
REQ-026 At most one bit of LDBUS, WR, INC SHALL be high in any cycle; LDBUS SHALL never be high while BOUT drives.
REQ-027 MOVE with SRC==DST, or any used index >= NREG: no strobes, no state change beyond IDLE; DONE=1 and ERR=1 at T+1, BUSY stays 0.
REQ-028 REQ asserted while BUSY=1 SHALL be ignored, not queued.
REQ-029 A new REQ SHALL be accepted in the DONE cycle (back-to-back throughput: MOVE every 3 cycles).
REQ-030 Changes on OP/SRC/DST/DIN after acceptance SHALL not affect the transfer in progress.
REQ-031 RDATA SHALL hold its value except on READ completion.

Reset
REQ-032 RST=0 at posedge SHALL force IDLE, LDBUS=WR=INC=0, BOUT=Z, BUSY=DONE=ERR=0, RDATA=0.
REQ-033 Reset has priority over all operations; reset mid-transfer SHALL abort without issuing further strobes or DONE.
REQ-034 REQ sampled in the same cycle as RST=0 SHALL be discarded.

Verification
REQ-035 MOVE SRC=2 DST=5, R2=0x1234 -> LDBUS=0x04 at T+1,T+2; WR=0x20 at T+2; R5=0x1234; DONE at T+3.
REQ-036 LOAD DST=1 DIN=0xBEEF -> BOUT=0xBEEF at T+1,T+2; WR=0x02 at T+2; R1=0xBEEF; BOUT=Z at T+3.
REQ-037 READ SRC=7, R7=0x00FF -> RDATA=0x00FF at T+3, DONE pulse, no WR.
REQ-038 INC DST=3 with R3=0xFFFF -> INC=0x08 single cycle, R3=0x0000, DONE at T+2.
REQ-039 MOVE SRC=DST=4 -> ERR=DONE=1 at T+1, all strobes 0; then REQ during BUSY ignored.
REQ-040 RST=0 at T+2 of MOVE -> WR=0 at T+2 is not issued after reset, all outputs reset values, no DONE.
